// File: rtl/rect_loop_pkg.sv
// Shared types and constants for the rectangle-loop scheduler.
// No logic; compile-time definitions only.
// No handshakes here; nothing to stall.
package rect_loop_pkg;

   localparam int PARAM_W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // Matrix is flattened row-major, one bit per cell.
   function automatic int mat_w(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/rect_loop_sched_if.sv
// Job, datapath and result signals between host, scheduler and datapath.
// Pure wiring; no latency.
// start and result use valid/ready; the datapath leg is a fixed-latency pipe.
interface rect_loop_sched_if
   import rect_loop_pkg::*;
#(
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   parameter int ITER_W = 8
) ();

   localparam int MAT_W = mat_w(ROWS, COLS);

   logic               start_valid;
   logic               start_ready;
   logic [MAT_W-1:0]   cfg_m;
   logic [ITER_W-1:0]  cfg_iters;
   logic [PARAM_W-1:0] cfg_param_base;
   logic [PARAM_W-1:0] cfg_param_step;
   logic               abort;
   logic               dp_valid;
   logic [PARAM_W-1:0] dp_param;
   logic [MAT_W-1:0]   dp_m;
   logic [MAT_W-1:0]   dp_m_in;
   logic               res_valid;
   logic               res_ready;
   logic [MAT_W-1:0]   res_m;
   logic [ITER_W-1:0]  res_iters_done;

   // Scheduler side: receives jobs and datapath results, produces operands and results.
   modport slave (
      input  start_valid, cfg_m, cfg_iters, cfg_param_base, cfg_param_step,
      input  abort, dp_m_in, res_ready,
      output start_ready, dp_valid, dp_param, dp_m, res_valid, res_m, res_iters_done
   );

   // Host/datapath side.
   modport master (
      output start_valid, cfg_m, cfg_iters, cfg_param_base, cfg_param_step,
      output abort, dp_m_in, res_ready,
      input  start_ready, dp_valid, dp_param, dp_m, res_valid, res_m, res_iters_done
   );

endinterface

// File: rtl/rect_loop_param_gen.sv
// 12-bit parameter accumulator: load a base, then add an increment per step.
// Value updates one edge after load/step.
// No handshake; load takes priority over step.
module rect_loop_param_gen
   import rect_loop_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [PARAM_W-1:0] base,
   input  logic               step,
   input  logic [PARAM_W-1:0] inc,
   output logic [PARAM_W-1:0] acc
);

   // Accumulator; the add wraps naturally at the register width.
   always_ff @(posedge clk) begin
      if (!reset)    acc <= '0;
      else if (load) acc <= base;
      else if (step) acc <= acc + inc;
   end

endmodule

// File: rtl/rect_loop_sched.sv
// Runs a job of N datapath iterations, feeding each result back as the next input.
// Result valid N*(DP_LAT+1)+1 cycles after accept (1 cycle for N=0).
// Holds the result until res_ready; start_ready only in IDLE, so no overlap of jobs.
module rect_loop_sched
   import rect_loop_pkg::*;
#(
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   parameter int DP_LAT = 1,
   parameter int ITER_W = 8
) (
   input logic              clk,
   input logic              reset,
   rect_loop_sched_if.slave bus
);

   localparam int         MAT_W  = mat_w(ROWS, COLS);
   localparam logic [3:0] LAST_W = 4'(DP_LAT);

   sched_state_t       state, state_nxt;
   logic [MAT_W-1:0]   work_m;
   logic [MAT_W-1:0]   res_m_q;
   logic [ITER_W-1:0]  iter_cnt;
   logic [ITER_W-1:0]  iter_inc;
   logic [ITER_W-1:0]  iters_lat;
   logic [ITER_W-1:0]  res_done_q;
   logic [3:0]         wcnt;
   logic [PARAM_W-1:0] step_lat;
   logic [PARAM_W-1:0] param_acc;
   logic               accept;
   logic               capture;
   logic               finish;

   assign iter_inc = iter_cnt + 1'b1;

   assign bus.start_ready    = (state == IDLE);
   assign bus.dp_valid       = (state == RUN);
   assign bus.dp_param       = param_acc;
   assign bus.dp_m           = work_m;
   assign bus.res_valid      = (state == DONE);
   assign bus.res_m          = res_m_q;
   assign bus.res_iters_done = res_done_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus accept/capture/finish strobes; a capture coinciding with abort still counts.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_valid) begin
               accept    = 1'b1;
               state_nxt = (bus.cfg_iters == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            capture = (wcnt == LAST_W);
            finish  = (capture && (iter_inc == iters_lat)) || bus.abort;
            if (finish) state_nxt = DONE;
         end
         DONE: begin
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job registers: latch config on accept, fold results back on capture, snapshot result on finish.
   always_ff @(posedge clk) begin
      if (!reset) begin
         work_m     <= '0;
         res_m_q    <= '0;
         iter_cnt   <= '0;
         iters_lat  <= '0;
         res_done_q <= '0;
         wcnt       <= '0;
         step_lat   <= '0;
      end else if (accept) begin
         work_m    <= bus.cfg_m;
         iter_cnt  <= '0;
         wcnt      <= '0;
         iters_lat <= bus.cfg_iters;
         step_lat  <= bus.cfg_param_step;
         if (bus.cfg_iters == '0) begin
            res_m_q    <= bus.cfg_m;
            res_done_q <= '0;
         end
      end else if (state == RUN) begin
         if (capture) begin
            work_m   <= bus.dp_m_in;
            iter_cnt <= iter_inc;
            wcnt     <= '0;
         end else begin
            wcnt <= wcnt + 1'b1;
         end
         if (finish) begin
            res_m_q    <= capture ? bus.dp_m_in : work_m;
            res_done_q <= capture ? iter_inc : iter_cnt;
         end
      end
   end

   rect_loop_param_gen u_param_gen (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .base  (bus.cfg_param_base),
      .step  (capture),
      .inc   (step_lat),
      .acc   (param_acc)
   );

endmodule

// File: tb/tb_rect_loop_sched.sv
// Randomized and directed checks of rect_loop_sched against an iteration-level model.
// Latency checked cycle by cycle against the model's expected completion cycle.
// Result port stalled for random cycle counts.
module tb_rect_loop_sched;

   localparam int DP_LAT = 1;
   localparam int L1     = DP_LAT + 1;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   rect_loop_sched_if #(.ROWS(2), .COLS(2), .ITER_W(8)) bus ();

   rect_loop_sched #(.ROWS(2), .COLS(2), .DP_LAT(DP_LAT), .ITER_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench datapath: registered m ^ param[3:0].
   always @(posedge clk) bus.dp_m_in <= bus.dp_m ^ bus.dp_param[3:0];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic int param_at(input int base, input int step, input int i);
      return (base + i * step) % 4096;
   endfunction

   // Expected matrix after k iterations of the feedback loop.
   function automatic logic [3:0] model_m(input logic [3:0] m0, input int base, input int step, input int k);
      logic [3:0] m;
      int p;
      m = m0;
      for (int i = 0; i < k; i++) begin
         p = param_at(base, step, i);
         m = m ^ 4'(p);
      end
      return m;
   endfunction

   // Runs one job from IDLE (called at a negedge), abort_k = cycle to abort in (0 = none).
   task automatic run_job(input logic [3:0] m0, input int n, input int base, input int step,
                          input int abort_k, input int hold);
      int end_c;
      int done_n;
      logic [3:0] exp_m;
      end_c = n * L1;
      if (abort_k > 0 && abort_k <= end_c) end_c = abort_k;
      done_n = end_c / L1;
      exp_m  = model_m(m0, base, step, done_n);

      check_val("start_ready_idle", 32'(bus.start_ready), 32'd1);
      bus.cfg_m          = m0;
      bus.cfg_iters      = 8'(n);
      bus.cfg_param_base = 12'(base);
      bus.cfg_param_step = 12'(step);
      bus.start_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start_valid    = 1'b0;
      // Scramble config to show it is not resampled.
      bus.cfg_m          = 4'($urandom);
      bus.cfg_iters      = 8'($urandom);
      bus.cfg_param_step = 12'($urandom);
      for (int c = 1; c <= end_c + 1; c++) begin
         check_val("start_ready_busy", 32'(bus.start_ready), 32'd0);
         check_val("res_valid_cycle", 32'(bus.res_valid), 32'(c == end_c + 1));
         if (c <= end_c) begin
            check_val("dp_valid_run", 32'(bus.dp_valid), 32'd1);
            check_val("dp_param", 32'(bus.dp_param), 32'(param_at(base, step, (c - 1) / L1)));
         end else begin
            check_val("dp_valid_done", 32'(bus.dp_valid), 32'd0);
            check_val("res_m", 32'(bus.res_m), 32'(exp_m));
            check_val("res_iters_done", 32'(bus.res_iters_done), 32'(done_n));
         end
         if (c <= end_c) begin
            bus.abort = (c == abort_k);
            @(posedge clk);
            @(negedge clk);
            bus.abort = 1'b0;
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("hold_res_valid", 32'(bus.res_valid), 32'd1);
         check_val("hold_res_m", 32'(bus.res_m), 32'(exp_m));
         check_val("hold_iters", 32'(bus.res_iters_done), 32'(done_n));
         check_val("hold_start_ready", 32'(bus.start_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check_val("back_idle_ready", 32'(bus.start_ready), 32'd1);
      check_val("back_idle_valid", 32'(bus.res_valid), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check_val("rst_start_ready", 32'(bus.start_ready), 32'd1);
      check_val("rst_dp_valid", 32'(bus.dp_valid), 32'd0);
      check_val("rst_dp_param", 32'(bus.dp_param), 32'd0);
      check_val("rst_dp_m", 32'(bus.dp_m), 32'd0);
      check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check_val("rst_res_m", 32'(bus.res_m), 32'd0);
      check_val("rst_res_iters", 32'(bus.res_iters_done), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.start_valid    = 1'b0;
      bus.cfg_m          = '0;
      bus.cfg_iters      = '0;
      bus.cfg_param_base = '0;
      bus.cfg_param_step = '0;
      bus.abort          = 1'b0;
      bus.res_ready      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;
      @(negedge clk);

      // Directed: basic, wrap, zero iterations, aborts, backpressure.
      run_job(4'b0110, 3, 12'h001, 12'h002, 0, 0);
      run_job(4'b1001, 2, 12'hFFF, 12'h002, 0, 1);
      run_job(4'b1010, 0, 12'h123, 12'h456, 0, 0);
      run_job(4'b0110, 3, 12'h001, 12'h002, 4, 0);
      run_job(4'b0110, 3, 12'h001, 12'h002, 3, 0);
      run_job(4'b0110, 3, 12'h001, 12'h002, 0, 5);
      // Abort while in IDLE must be ignored.
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      check_val("abort_idle_ready", 32'(bus.start_ready), 32'd1);
      check_val("abort_idle_valid", 32'(bus.res_valid), 32'd0);

      // Reset during iteration 2.
      bus.cfg_m = 4'b0110; bus.cfg_iters = 8'd3;
      bus.cfg_param_base = 12'h001; bus.cfg_param_step = 12'h002;
      bus.start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("post_rst_no_res", 32'(bus.res_valid), 32'd0);
         check_val("post_rst_no_dp", 32'(bus.dp_valid), 32'd0);
      end
      run_job(4'b0110, 3, 12'h001, 12'h002, 0, 0);

      // Randomized jobs.
      for (int j = 0; j < 40; j++) begin
         int n;
         int ak;
         n  = $urandom_range(0, 6);
         ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * L1 + 2) : 0;
         run_job(4'($urandom), n, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                 ak, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rect_loop_sched.md
Name: rect_loop_sched

Overview:
Sequencing controller for the rectangle-loop datapath (rectangle_loop_2 family). It accepts a job: initial binary matrix, iteration count, param base and step. It then drives the datapath once per iteration, feeding each result back as the next input, and returns the final matrix through a valid/ready result port. It sits between the host/config logic and one datapath instance.

Parameters:
ROWS, 2, matrix rows
COLS, 2, matrix columns
DP_LAT, 1, edges from dp_param/dp_m presented to dp_m_in valid; legal range 0..15
ITER_W, 8, width of iteration count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start_valid  in  1  job request
start_ready  out  1  high only in IDLE
cfg_m  in  ROWS*COLS  initial matrix, row-major, bit [r*COLS+c]
cfg_iters  in  ITER_W  number of iterations
cfg_param_base  in  12  param for iteration 0
cfg_param_step  in  12  param increment per iteration
abort  in  1  stop the job early
dp_valid  out  1  datapath operands valid
dp_param  out  12  param to datapath
dp_m  out  ROWS*COLS  matrix to datapath
dp_m_in  in  ROWS*COLS  datapath result
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_m  out  ROWS*COLS  final matrix
res_iters_done  out  ITER_W  iterations actually completed

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state IDLE
  - start_ready=1
  - dp_valid=0, dp_param=0, dp_m=0
  - res_valid=0, res_m=0, res_iters_done=0
  - all counters 0
- Reset mid-job discards the job; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - An accept occurs on start_valid&start_ready at an edge.
  - On accept: work_m<=cfg_m, param_acc<=cfg_param_base, iter_cnt<=0, wcnt<=0.
  - Next state is RUN if cfg_iters!=0; otherwise DONE with res_m=cfg_m and res_iters_done=0.
- RUN:
  - dp_valid=1; dp_m=work_m; dp_param=param_acc. These are register-driven and held stable for the whole iteration.
  - Each iteration lasts exactly DP_LAT+1 cycles, with wcnt counting 0..DP_LAT.
  - At the edge ending the cycle where wcnt==DP_LAT:
    - work_m<=dp_m_in
    - iter_cnt++
    - param_acc<=param_acc+cfg_param_step (latched step), mod 4096, wrap silently
    - wcnt<=0
  - When iter_cnt reaches cfg_iters (latched), go to DONE.
- Timing: for N>=1, res_valid is first high N*(DP_LAT+1)+1 cycles after the accept edge, counting the cycle after accept as cycle 1. For N=0, res_valid is high in the cycle after accept.
- abort in RUN:
  - Next state DONE; res_m=work_m (last completed result); res_iters_done=iter_cnt.
  - If abort coincides with a capture edge, the capture completes first and is counted, then DONE.
  - abort is ignored in IDLE and DONE.
- DONE:
  - res_valid=1; res_m and res_iters_done held stable; dp_valid=0.
  - At an edge with res_ready=1, go to IDLE. The next job cannot be accepted in the same cycle.
- Config inputs are sampled only at accept; later changes have no effect on the running job.

Decomposition:
- rect_loop_pkg contains:
  - PARAM_W=12
  - state enum sched_state_t {IDLE,RUN,DONE}
  - localparam function for MAT_W=ROWS*COLS
- Sub-module rect_loop_param_gen: 12-bit accumulator with load(base) and step(inc), wrapping mod 4096.

Test Plan:
All scenarios use ROWS=COLS=2, DP_LAT=1, and a bench datapath model that registers m ^ param[3:0].
1. Basic job: cfg_m=4'b0110, iters=3, base=12'h001, step=12'h002.
   -> dp_param sequence 001, 003, 005, each held 2 cycles.
   -> res_m=4'b0001, res_iters_done=3.
   -> res_valid first high 7 cycles after accept.
2. Param wrap: base=12'hFFF, step=12'h002, iters=2.
   -> dp_param FFF then 001.
   -> res_m = cfg_m ^ 4'hF ^ 4'h1.
3. Zero iterations: iters=0, cfg_m=4'b1010.
   -> dp_valid never asserts; res_valid the next cycle with res_m=4'b1010, res_iters_done=0.
4. Abort: scenario 1 with abort pulsed on the second iteration's capture cycle.
   -> res_iters_done=2, res_m=4'b0100.
   -> A separate abort on the first cycle of iteration 2 gives res_iters_done=1, res_m=4'b0111.
5. Backpressure: res_ready=0 for 5 cycles after res_valid.
   -> res_valid/res_m stable and start_ready=0 throughout.
   -> IDLE with start_ready=1 one cycle after res_ready=1.
6. Reset mid-RUN: assert reset=0 during iteration 2 of scenario 1.
   -> All outputs return to reset values next edge; no res_valid; a new job then runs correctly.
